// File: rtl/pong_engine.sv
// Pong game-state engine: paddles, ball motion, scoring and serve/play/game-over sequencing.
// Everything advances on a prescaled game tick except the single-cycle POINT state.
module pong_engine #(
  parameter int SCREEN_W    = 96,
  parameter int SCREEN_H    = 64,
  parameter int PADDLE_H    = 16,
  parameter int PADDLE_W    = 4,
  parameter int BALL_R      = 2,
  parameter int WIN_SCORE   = 9,
  parameter int TICK_DIV    = 131072,
  parameter int SERVE_TICKS = 32,
  localparam int XW = $clog2(SCREEN_W+1),
  localparam int YW = $clog2(SCREEN_H+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p1_up,
  input  logic          p1_down,
  input  logic          p2_up,
  input  logic          p2_down,
  input  logic          start,
  output logic [YW-1:0] paddle1_y,
  output logic [YW-1:0] paddle2_y,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y,
  output logic [3:0]    score1,
  output logic [3:0]    score2,
  output logic          game_over,
  output logic          serving,
  output logic          point_p1,
  output logic          point_p2
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SRV_W = $clog2(SERVE_TICKS+1);
  localparam logic [XW-1:0] CX   = XW'(SCREEN_W/2);
  localparam logic [YW-1:0] CY   = YW'(SCREEN_H/2);
  localparam logic [YW-1:0] PAD0 = YW'((SCREEN_H-PADDLE_H)/2);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_GAMEOVER} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  presc_q, presc_d;
  logic [SRV_W-1:0]  srv_q, srv_d;
  logic [YW-1:0]     pad1_q, pad1_d, pad2_q, pad2_d;
  logic [XW-1:0]     bx_q, bx_d;
  logic [YW-1:0]     by_q, by_d;
  logic              dirx_q, dirx_d;   // 1 = moving right
  logic              diry_q, diry_d;   // 1 = moving down
  logic [3:0]        s1_q, s1_d, s2_q, s2_d;
  logic              scorer_q, scorer_d; // 1 = player 1 scored
  logic              pt1_q, pt1_d, pt2_q, pt2_d;
  logic              go_q, serv_q;
  logic              tick;

  function automatic logic [YW-1:0] pad_step(input logic [YW-1:0] y, input logic up,
                                             input logic dn);
    logic [YW-1:0] r;
    r = y;
    if (up && !dn && y != '0)
      r = y - YW'(1);
    else if (dn && !up && int'(y) < SCREEN_H-PADDLE_H)
      r = y + YW'(1);
    return r;
  endfunction

  assign tick = (presc_q == CNT_W'(TICK_DIV-1));

  always_comb begin
    int bx, by, p1, p2;
    logic ndx, ndy;
    logic [3:0] ns;
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + CNT_W'(1);
    srv_d    = srv_q;
    pad1_d   = pad1_q;
    pad2_d   = pad2_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dirx_d   = dirx_q;
    diry_d   = diry_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    scorer_d = scorer_q;
    pt1_d    = 1'b0;
    pt2_d    = 1'b0;
    bx  = int'(bx_q);
    by  = int'(by_q);
    p1  = int'(pad1_q);
    p2  = int'(pad2_q);
    ndx = dirx_q;
    ndy = diry_q;
    ns  = '0;

    if (tick && state_q != S_GAMEOVER) begin
      pad1_d = pad_step(pad1_q, p1_up, p1_down);
      pad2_d = pad_step(pad2_q, p2_up, p2_down);
    end

    case (state_q)
      S_IDLE: begin
        bx_d = CX;
        by_d = CY;
        if (start) begin
          state_d = S_SERVE;
          s1_d    = '0;
          s2_d    = '0;
          dirx_d  = 1'b1;
          srv_d   = '0;
        end
      end
      S_SERVE: begin
        bx_d = CX;
        by_d = CY;
        if (tick) begin
          if (srv_q == SRV_W'(SERVE_TICKS-1)) begin
            state_d = S_PLAY;
            srv_d   = '0;
          end else begin
            srv_d = srv_q + SRV_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (!dirx_q && bx == BALL_R) begin
            state_d  = S_POINT;
            scorer_d = 1'b0;
          end else if (dirx_q && bx + BALL_R == SCREEN_W) begin
            state_d  = S_POINT;
            scorer_d = 1'b1;
          end else begin
            if (!diry_q && by == BALL_R)
              ndy = 1'b1;
            else if (diry_q && by + BALL_R == SCREEN_H)
              ndy = 1'b0;
            // A paddle hit decides dir_y from which half of the paddle was struck.
            if (!dirx_q && bx - BALL_R == PADDLE_W &&
                by + BALL_R > p1 && by - BALL_R < p1 + PADDLE_H) begin
              ndx = 1'b1;
              ndy = !(by < p1 + PADDLE_H/2);
            end else if (dirx_q && bx + BALL_R == SCREEN_W - PADDLE_W &&
                         by + BALL_R > p2 && by - BALL_R < p2 + PADDLE_H) begin
              ndx = 1'b0;
              ndy = !(by < p2 + PADDLE_H/2);
            end
            dirx_d = ndx;
            diry_d = ndy;
            bx_d   = ndx ? bx_q + XW'(1) : bx_q - XW'(1);
            by_d   = ndy ? by_q + YW'(1) : by_q - YW'(1);
          end
        end
      end
      S_POINT: begin
        bx_d   = CX;
        by_d   = CY;
        diry_d = ~diry_q;
        srv_d  = '0;
        if (scorer_q) begin
          ns     = (int'(s1_q) < WIN_SCORE) ? s1_q + 4'd1 : s1_q;
          s1_d   = ns;
          pt1_d  = 1'b1;
          dirx_d = 1'b1;
        end else begin
          ns     = (int'(s2_q) < WIN_SCORE) ? s2_q + 4'd1 : s2_q;
          s2_d   = ns;
          pt2_d  = 1'b1;
          dirx_d = 1'b0;
        end
        state_d = (ns == 4'(WIN_SCORE)) ? S_GAMEOVER : S_SERVE;
      end
      S_GAMEOVER: begin
        bx_d = CX;
        by_d = CY;
        if (start) begin
          state_d = S_SERVE;
          s1_d    = '0;
          s2_d    = '0;
          dirx_d  = 1'b1;
          srv_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      srv_q    <= '0;
      pad1_q   <= PAD0;
      pad2_q   <= PAD0;
      bx_q     <= CX;
      by_q     <= CY;
      dirx_q   <= 1'b1;
      diry_q   <= 1'b1;
      s1_q     <= '0;
      s2_q     <= '0;
      scorer_q <= 1'b0;
      pt1_q    <= 1'b0;
      pt2_q    <= 1'b0;
      go_q     <= 1'b0;
      serv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      srv_q    <= srv_d;
      pad1_q   <= pad1_d;
      pad2_q   <= pad2_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dirx_q   <= dirx_d;
      diry_q   <= diry_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      scorer_q <= scorer_d;
      pt1_q    <= pt1_d;
      pt2_q    <= pt2_d;
      go_q     <= (state_d == S_GAMEOVER);
      serv_q   <= (state_d == S_SERVE);
    end
  end

  assign paddle1_y = pad1_q;
  assign paddle2_y = pad2_q;
  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign score1    = s1_q;
  assign score2    = s2_q;
  assign game_over = go_q;
  assign serving   = serv_q;
  assign point_p1  = pt1_q;
  assign point_p2  = pt2_q;

endmodule

// File: tb/tb_pong_engine.sv
// Scoreboard bench for pong_engine: expected ball/paddle/point events are queued by the
// stimulus and consumed by a monitor whenever the DUT's outputs change or a point strobes.
module tb_pong_engine;

  localparam int XW = 7;
  localparam int YW = 7;

  logic clk, rst;
  logic p1_up, p1_down, p2_up, p2_down, start;
  logic [YW-1:0] paddle1_y, paddle2_y, ball_y;
  logic [XW-1:0] ball_x;
  logic [3:0] score1, score2;
  logic game_over, serving, point_p1, point_p2;

  pong_engine #(
    .SCREEN_W(96), .SCREEN_H(64), .PADDLE_H(16), .PADDLE_W(4), .BALL_R(2),
    .WIN_SCORE(2), .TICK_DIV(4), .SERVE_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .start(start),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .score1(score1), .score2(score2),
    .game_over(game_over), .serving(serving),
    .point_p1(point_p1), .point_p2(point_p2)
  );

  typedef struct {int a; int b;} pair_t;
  typedef struct {int who; int s1; int s2;} pt_t;

  pair_t ball_q[$];
  pair_t pad_q[$];
  pt_t   pt_q[$];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_line(input int x0, input int y0, input int dx, input int dy, input int n);
    pair_t p;
    for (int i = 0; i < n; i++) begin
      p.a = x0 + i*dx;
      p.b = y0 + i*dy;
      ball_q.push_back(p);
    end
  endtask

  task automatic push_pad(input int a0, input int da, input int b0, input int db, input int n);
    pair_t p;
    for (int i = 0; i < n; i++) begin
      p.a = a0 + i*da;
      p.b = b0 + i*db;
      pad_q.push_back(p);
    end
  endtask

  task automatic push_pt(input int who, input int s1, input int s2);
    pt_t p;
    p.who = who;
    p.s1  = s1;
    p.s2  = s2;
    pt_q.push_back(p);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_paddle1_y"}, int'(paddle1_y), 24);
    chk({tag, "_paddle2_y"}, int'(paddle2_y), 24);
    chk({tag, "_ball_x"}, int'(ball_x), 48);
    chk({tag, "_ball_y"}, int'(ball_y), 32);
    chk({tag, "_score1"}, int'(score1), 0);
    chk({tag, "_score2"}, int'(score2), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_serving"}, int'(serving), 0);
    chk({tag, "_points"}, int'({point_p1, point_p2}), 0);
  endtask

  // Monitor: consumes one expectation per observed output event.
  initial begin
    int pbx, pby, pp1, pp2;
    logic pprev;
    pair_t e;
    pt_t t;
    @(negedge clk);
    pbx = int'(ball_x); pby = int'(ball_y);
    pp1 = int'(paddle1_y); pp2 = int'(paddle2_y);
    pprev = 1'b0;
    forever begin
      @(negedge clk);
      if (int'(ball_x) != pbx || int'(ball_y) != pby) begin
        if (ball_q.size() == 0) begin
          chk("ball_unexpected_move_x", int'(ball_x), pbx);
        end else begin
          e = ball_q.pop_front();
          checks++;
          if (int'(ball_x) != e.a || int'(ball_y) != e.b) begin
            errors++;
            $display("FAIL ball_pos: got (%0d,%0d) expected (%0d,%0d)", ball_x, ball_y, e.a, e.b);
          end
          $display("ball (%0d,%0d)", ball_x, ball_y);
        end
        pbx = int'(ball_x); pby = int'(ball_y);
      end
      if (int'(paddle1_y) != pp1 || int'(paddle2_y) != pp2) begin
        if (pad_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL paddle_unexpected_move: got (%0d,%0d) expected (%0d,%0d)",
                   paddle1_y, paddle2_y, pp1, pp2);
        end else begin
          e = pad_q.pop_front();
          checks++;
          if (int'(paddle1_y) != e.a || int'(paddle2_y) != e.b) begin
            errors++;
            $display("FAIL paddles: got (%0d,%0d) expected (%0d,%0d)", paddle1_y, paddle2_y, e.a, e.b);
          end
          $display("paddles (%0d,%0d)", paddle1_y, paddle2_y);
        end
        pp1 = int'(paddle1_y); pp2 = int'(paddle2_y);
      end
      if (pprev) begin
        chk("point_one_cycle", int'(point_p1 | point_p2), 0);
      end else if (point_p1 || point_p2) begin
        if (pt_q.size() == 0) begin
          chk("point_unexpected", int'({point_p1, point_p2}), 0);
        end else begin
          t = pt_q.pop_front();
          chk("point_who", point_p1 ? 1 : 2, t.who);
          chk("point_score1", int'(score1), t.s1);
          chk("point_score2", int'(score2), t.s2);
          $display("point p%0d score %0d-%0d", point_p1 ? 1 : 2, score1, score2);
        end
      end
      pprev = point_p1 | point_p2;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0; start = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    repeat (20) @(negedge clk);
    chk("idle_serving", int'(serving), 0);
    chk("idle_game_over", int'(game_over), 0);

    // Paddle clamps: 30 ticks up, 60 ticks down, then both buttons
    push_pad(23, -1, 24, 0, 24);
    p1_up = 1; repeat (120) @(negedge clk); p1_up = 0;
    chk("p1_top_clamp", int'(paddle1_y), 0);
    push_pad(1, 1, 24, 0, 48);
    p1_down = 1; repeat (240) @(negedge clk); p1_down = 0;
    chk("p1_bottom_clamp", int'(paddle1_y), 48);
    p1_up = 1; p1_down = 1; repeat (20) @(negedge clk); p1_up = 0; p1_down = 0;
    chk("p1_both_pressed", int'(paddle1_y), 48);
    push_pad(47, -1, 24, 0, 16);
    p1_up = 1; repeat (64) @(negedge clk); p1_up = 0;
    push_pad(32, 0, 25, 1, 24);
    p2_down = 1; repeat (120) @(negedge clk); p2_down = 0;
    chk("p2_at_48", int'(paddle2_y), 48);

    // Round 1: bottom bounce, paddle2 hit, paddle1 hit, then paddle2 misses
    push_line(49, 33, 1, 1, 30);
    push_line(79, 61, 1, -1, 12);
    push_line(89, 49, -1, -1, 48);
    push_line(41, 3, -1, 1, 36);
    push_line(7, 37, 1, -1, 36);
    push_line(43, 3, 1, 1, 52);
    push_line(48, 32, 0, 0, 1);
    push_pt(1, 1, 0);
    start = 1; @(negedge clk); start = 0;
    chk("start_serving", int'(serving), 1);
    n = 0;
    while (!(ball_x == 7'd89 && ball_y == 7'd49) && n < 1000) begin @(negedge clk); n++; end
    chk("reach_after_hit_x", int'(ball_x), 89);
    push_pad(32, 0, 47, -1, 48);
    p2_up = 1; repeat (240) @(negedge clk); p2_up = 0;
    n = 0;
    while (!point_p1 && n < 2000) begin @(negedge clk); n++; end
    chk("round1_point_seen", int'(point_p1), 1);
    @(negedge clk);
    chk("round1_serving", int'(serving), 1);
    chk("round1_score1", int'(score1), 1);

    // Round 2: paddle2 lowered out of the way, second P1 point ends the game
    push_pad(32, 0, 1, 1, 20);
    push_line(49, 31, 1, -1, 30);
    push_line(79, 3, 1, 1, 16);
    push_line(48, 32, 0, 0, 1);
    push_pt(1, 2, 0);
    p2_down = 1; repeat (80) @(negedge clk); p2_down = 0;
    n = 0;
    while (!game_over && n < 1000) begin @(negedge clk); n++; end
    chk("game_over_set", int'(game_over), 1);
    chk("gameover_score1", int'(score1), 2);
    chk("gameover_score2", int'(score2), 0);
    chk("gameover_serving", int'(serving), 0);
    p1_up = 1; repeat (20) @(negedge clk); p1_up = 0;
    chk("frozen_ball_x", int'(ball_x), 48);
    chk("frozen_ball_y", int'(ball_y), 32);
    chk("frozen_paddle1", int'(paddle1_y), 32);
    chk("frozen_game_over", int'(game_over), 1);

    // Restart, then reset in the middle of play
    push_line(49, 31, 1, -1, 5);
    start = 1; @(negedge clk); start = 0;
    chk("restart_score1", int'(score1), 0);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_serving", int'(serving), 1);
    n = 0;
    while (ball_x != 7'd53 && n < 200) begin @(negedge clk); n++; end
    chk("round3_reach_x", int'(ball_x), 53);
    push_line(48, 32, 0, 0, 1);
    push_pad(24, 0, 24, 0, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("midplay_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_serving", int'(serving), 0);
    chk("post_rst_ball_x", int'(ball_x), 48);

    repeat (2) @(negedge clk);
    chk("ball_queue_empty", ball_q.size(), 0);
    chk("pad_queue_empty", pad_q.size(), 0);
    chk("point_queue_empty", pt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
